my_mux_nway_rr: RTL

- Parametrised N-way, W-bit selector with per-input valid/ready handshakes and a one-entry registered output stage.
- Successor to the combinational 8-way/16-bit mux tree.
- Two selection modes:
  - explicit select, the legacy behaviour;
  - round-robin arbitration among valid inputs.
- Feeds the datapath wherever several producers share one 16-bit consumer, e.g. memory-write and ALU-result funnelling.

---
 rtl/my_mux_nway_rr_pkg.sv | 17 +
 rtl/my_rr_arbiter.sv | 42 ++++
 rtl/my_mux_nway_rr.sv | 97 +++++++++
 3 files changed

// File: rtl/my_mux_nway_rr_pkg.sv
// Shared definitions for the N-way round-robin selector: mode encodings and
// the index-width helper used to size select/grant buses.
package my_mux_nway_rr_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/my_rr_arbiter.sv
// Round-robin arbiter: rotates the request vector so the channel after ptr
// sits at bit 0, priority-encodes the lowest set bit, then un-rotates.
module my_rr_arbiter
  import my_mux_nway_rr_pkg::*;
#(
  parameter int WAYS  = 8,
  parameter int SEL_W = clog2(WAYS)
) (
  input  logic [WAYS-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [WAYS-1:0]  grant,
  output logic [SEL_W-1:0] idx,
  output logic             any_grant
);

  logic [SEL_W:0]    start;
  logic [2*WAYS-1:0] dbl;
  logic [WAYS-1:0]   rot;
  int                off;
  int                sum;

  always_comb begin
    // start may equal WAYS (ptr = WAYS-1); the doubled vector makes that
    // shift land exactly on the unrotated request.
    start     = {1'b0, ptr} + (SEL_W+1)'(1);
    dbl       = {req, req} >> start;
    rot       = dbl[WAYS-1:0];
    any_grant = |req;
    off       = 0;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = int'(ptr) + 1 + off;
    if (sum >= WAYS) sum = sum - WAYS;
    idx   = SEL_W'(sum);
    grant = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (any_grant && (sum == k)) grant[k] = 1'b1;
    end
  end

endmodule

// File: rtl/my_mux_nway_rr.sv
// N-way, W-bit selector with per-channel valid/ready, explicit-select or
// round-robin mode, and a one-entry registered output stage.
module my_mux_nway_rr
  import my_mux_nway_rr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]       in_valid,
  output logic [WAYS-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel
);

  // Handshake: a word moves on channel i when in_valid[i] && in_ready[i] at a
  // rising edge, and leaves the output stage when out_valid && out_ready.
  // in_ready is one-hot at most, depends on in_valid (never the reverse), and
  // is recomputed every cycle, so a producer may withdraw valid freely.

  logic [SEL_W-1:0] ptr;
  logic [WAYS-1:0]  arb_grant;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;

  logic             can_load;
  logic             sel_hit;
  logic [WAYS-1:0]  sel_oh;
  logic             any_grant;
  logic [WAYS-1:0]  grant_oh;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  my_rr_arbiter #(
    .WAYS  (WAYS),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .idx       (arb_idx),
    .any_grant (arb_any)
  );

  always_comb begin
    can_load = !out_valid || out_ready;
    // An out-of-range sel matches no loop index and therefore never grants.
    sel_hit = 1'b0;
    sel_oh  = '0;
    for (int i = 0; i < WAYS; i++) begin
      if ((sel == SEL_W'(i)) && in_valid[i]) begin
        sel_hit   = 1'b1;
        sel_oh[i] = 1'b1;
      end
    end
    if (mode == MODE_RR) begin
      grant_oh  = arb_grant;
      grant_idx = arb_idx;
      any_grant = arb_any;
    end else begin
      grant_oh  = sel_oh;
      grant_idx = sel;
      any_grant = sel_hit;
    end
    xfer     = can_load && any_grant && !reset;
    in_ready = xfer ? grant_oh : '0;
    grant_data = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(WAYS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
      if (mode == MODE_RR) ptr <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
